hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter NLATCH, default 4: number of pipeline latches; index 0=IFID, 1=IDEX, 2=EXMEM, 3=MEMWB.
REQ-002 SHALL have parameter FWD_EN, default 1: 1 = forwarding present; 0 = stall on every RAW hazard.
REQ-003 SHALL have parameter LOAD_LAT, default 1, range 1..4: load-use bubble count when FWD_EN=1.
REQ-004 SHALL have parameter CNTW, default 32: stall performance counter width.
REQ-005 Ports (name  dir  width  meaning):
- CLK  in  1  single clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit, dhit  in  1  instruction/data cache hit.
- rs, rt  in  regbits_t  ID-stage source registers.
- rs_used, rt_used  in  1  each source actually read.
- idex_wsel, exmem_wsel, memwb_wsel  in  regbits_t  destination register per latch.
- idex_wen, exmem_wen, memwb_wen  in  1  latch writes the register file.
- idex_memrd  in  1  IDEX instruction is a load.
- exmem_memop  in  1  EXMEM instruction is a load/store.
- branch_taken  in  1  EX resolved a taken branch/jump.
- exmem_halt  in  1  halt has reached EXMEM.
- pcWEN  out  1  PC write enable.
- latch_en, latch_flush  out  NLATCH  per-latch enable/flush.
- fwd_a, fwd_b  out  fwd_sel_t  operand forward select.
- stall_cnt  out  CNTW  stall-cycle counter.

Function
REQ-006 SHALL implement FSM hz_state_t {RUN, LU_STALL, MEM_WAIT, HALTED}.
REQ-007 Event priority SHALL be: HALTED > mem wait > branch > load-use/RAW > ihit miss.
REQ-008 Mem wait (exmem_memop && !dhit) SHALL drive pcWEN=0, latch_en all 0, latch_flush all 0; SHALL enter MEM_WAIT and return to RUN on the cycle dhit=1.
REQ-009 On branch_taken outside a mem wait, outputs SHALL be pcWEN=1, latch_flush[0]=latch_flush[1]=1, other latches enabled; a pending LU_STALL SHALL be cancelled to RUN.
REQ-010 Load-use (FWD_EN=1) SHALL be detected when idex_memrd && idex_wen && idex_wsel!=0 && ((rs_used && rs==idex_wsel) || (rt_used && rt==idex_wsel)).
REQ-011 On load-use, outputs SHALL be pcWEN=0, latch_en[0]=0, latch_flush[1]=1, latches 2.. enabled; SHALL load stall counter with LOAD_LAT-1; SHALL enter LU_STALL if nonzero, else stay RUN.
REQ-012 LU_STALL SHALL hold the REQ-011 outputs and decrement each cycle; SHALL exit to RUN when the counter reads 0.
REQ-013 With FWD_EN=0, a RAW hazard against any of IDEX/EXMEM/MEMWB (wen=1, wsel!=0, wsel matches a used source) SHALL apply REQ-011 outputs, re-evaluated every cycle; the counter SHALL be unused.
REQ-014 Forward select: fwd_x=FWD_EXMEM (01) if exmem_wen && exmem_wsel!=0 && match; else FWD_MEMWB (10) on the same rule for MEMWB; else FWD_NONE (00). EXMEM SHALL win ties.
REQ-015 With FWD_EN=0, fwd_a and fwd_b SHALL be 00.
REQ-016 Forward select SHALL be combinational with zero latency.
REQ-017 ihit=0 with no higher event SHALL drive pcWEN=0, latch_flush[0]=1, remaining latches enabled.
REQ-018 exmem_halt=1 SHALL enter HALTED next cycle.
REQ-019 HALTED SHALL drive pcWEN=0, latch_flush[0]=1, other latches enabled so the pipeline drains, and SHALL remain until RST.
REQ-020 stall_cnt SHALL increment each cycle pcWEN=0 outside HALTED and reset, and SHALL saturate at all-ones.
REQ-021 In RUN with no event, outputs SHALL be pcWEN=1, latch_en all 1, latch_flush all 0.

Reset
REQ-022 On RST=1 at a CLK edge: state=RUN, stall counter=0, stall_cnt=0.
REQ-023 While RST=1, outputs SHALL be pcWEN=0, latch_en=0, latch_flush all 1, fwd_a=fwd_b=00.
REQ-024 RST mid-stall or in HALTED SHALL abort to RUN with no residual count.

Structure
REQ-025 cpu_types_pkg SHALL hold regbits_t, hz_state_t and fwd_sel_t (FWD_NONE, FWD_EXMEM, FWD_MEMWB).
REQ-026 Operand forwarding SHALL be one sub-module, hazard_fwd, instantiated twice (A, B); the FSM and counters SHALL reside in hazard_ctrl.

Verification
REQ-027 Load-use, LOAD_LAT=3: lw $5 in IDEX, rs=5 -> pcWEN=0 for exactly 3 cycles; latch_flush[1]=1 each of those cycles; stall_cnt=3.
REQ-028 Mem wait: exmem_memop=1, dhit=0 for 4 cycles, branch_taken=1 concurrently -> all latch_en=0, no flush, for 4 cycles; branch flush on the 5th cycle.
REQ-029 Forward tie: exmem_wsel=memwb_wsel=7, both wen=1, rs=7 -> fwd_a=01; rs=0 with wsel=0 -> fwd_a=00.
REQ-030 FWD_EN=0: add writing $3 in IDEX, rt=3 used -> stall until the writer leaves MEMWB (3 cycles); fwd_b=00 throughout.
REQ-031 Halt then reset: exmem_halt=1 -> HALTED; 10 cycles with pcWEN=0 and stall_cnt unchanged; RST=1 for 1 cycle -> RUN, stall_cnt=0.
REQ-032 Saturation with CNTW=4: 20 ihit=0 cycles -> stall_cnt=15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types for hazard detection and operand forwarding.
package cpu_types_pkg;

  localparam int unsigned REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  // A source depends on a latch when the latch writes a non-zero register it reads.
  function automatic logic src_hit(input regbits_t src, input logic used,
                                   input regbits_t wsel, input logic wen);
    return wen && used && (wsel != '0) && (src == wsel);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-status inputs and stall/flush/forward outputs of the hazard unit.
interface hazard_ctrl_if #(
  parameter int unsigned NLATCH = 4,
  parameter int unsigned CNTW   = 32
);
  import cpu_types_pkg::*;

  logic              ihit;
  logic              dhit;
  regbits_t          rs;
  regbits_t          rt;
  logic              rs_used;
  logic              rt_used;
  regbits_t          idex_wsel;
  regbits_t          exmem_wsel;
  regbits_t          memwb_wsel;
  logic              idex_wen;
  logic              exmem_wen;
  logic              memwb_wen;
  logic              idex_memrd;
  logic              exmem_memop;
  logic              branch_taken;
  logic              exmem_halt;
  logic              pcWEN;
  logic [NLATCH-1:0] latch_en;
  logic [NLATCH-1:0] latch_flush;
  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;
  logic [CNTW-1:0]   stall_cnt;

  modport master (
    output ihit, dhit, rs, rt, rs_used, rt_used,
           idex_wsel, exmem_wsel, memwb_wsel, idex_wen, exmem_wen, memwb_wen,
           idex_memrd, exmem_memop, branch_taken, exmem_halt,
    input  pcWEN, latch_en, latch_flush, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  ihit, dhit, rs, rt, rs_used, rt_used,
           idex_wsel, exmem_wsel, memwb_wsel, idex_wen, exmem_wen, memwb_wen,
           idex_memrd, exmem_memop, branch_taken, exmem_halt,
    output pcWEN, latch_en, latch_flush, fwd_a, fwd_b, stall_cnt
  );

endinterface

// File: rtl/hazard_fwd.sv
// Operand forward select for one ID source; EXMEM has the newer value and wins ties.
module hazard_fwd
  import cpu_types_pkg::*;
#(
  parameter int unsigned FWD_EN = 1
) (
  input  regbits_t src,
  input  regbits_t exmem_wsel,
  input  logic     exmem_wen,
  input  regbits_t memwb_wsel,
  input  logic     memwb_wen,
  output fwd_sel_t sel_c
);

  always_comb begin
    sel_c = FWD_NONE;
    if (FWD_EN != 0) begin
      if (src_hit(src, 1'b1, exmem_wsel, exmem_wen))
        sel_c = FWD_EXMEM;
      else if (src_hit(src, 1'b1, memwb_wsel, memwb_wen))
        sel_c = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush sequencing, halt handling, stall counter,
// and operand forward selection.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned NLATCH   = 4,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNTW     = 32
) (
  input logic          CLK,
  input logic          RST,
  hazard_ctrl_if.slave hz
);

  localparam int unsigned LUW = 2;
  localparam logic [LUW-1:0] LU_INIT = LUW'(LOAD_LAT - 1);

  hz_state_t         state, state_nxt;
  logic [LUW-1:0]    lu_cnt, lu_nxt;
  logic [CNTW-1:0]   stall_cnt;
  logic              pc_wen;
  logic [NLATCH-1:0] latch_en, latch_flush;
  logic              mem_wait, load_use, raw, hazard;
  fwd_sel_t          fwd_a_c, fwd_b_c;

  assign mem_wait = hz.exmem_memop && !hz.dhit;

  assign load_use = hz.idex_memrd &&
                    (src_hit(hz.rs, hz.rs_used, hz.idex_wsel, hz.idex_wen) ||
                     src_hit(hz.rt, hz.rt_used, hz.idex_wsel, hz.idex_wen));

  // Without forwarding any in-flight writer of a source must drain first.
  assign raw = src_hit(hz.rs, hz.rs_used, hz.idex_wsel,  hz.idex_wen)  ||
               src_hit(hz.rt, hz.rt_used, hz.idex_wsel,  hz.idex_wen)  ||
               src_hit(hz.rs, hz.rs_used, hz.exmem_wsel, hz.exmem_wen) ||
               src_hit(hz.rt, hz.rt_used, hz.exmem_wsel, hz.exmem_wen) ||
               src_hit(hz.rs, hz.rs_used, hz.memwb_wsel, hz.memwb_wen) ||
               src_hit(hz.rt, hz.rt_used, hz.memwb_wsel, hz.memwb_wen);

  assign hazard = (FWD_EN != 0) ? load_use : raw;

  // Next state and stall/flush outputs, highest-priority event first.
  always_comb begin
    state_nxt   = state;
    lu_nxt      = lu_cnt;
    pc_wen      = 1'b1;
    latch_en    = '1;
    latch_flush = '0;
    if (state == HALTED) begin
      pc_wen         = 1'b0;
      latch_flush[0] = 1'b1;
    end else if (mem_wait) begin
      pc_wen    = 1'b0;
      latch_en  = '0;
      state_nxt = MEM_WAIT;
    end else if (hz.branch_taken) begin
      latch_flush[1:0] = 2'b11;
      lu_nxt           = '0;
      state_nxt        = RUN;
    end else if (state == LU_STALL) begin
      pc_wen         = 1'b0;
      latch_en[0]    = 1'b0;
      latch_flush[1] = 1'b1;
      lu_nxt         = lu_cnt - LUW'(1);
      state_nxt      = (lu_nxt == '0) ? RUN : LU_STALL;
    end else if (hazard) begin
      pc_wen         = 1'b0;
      latch_en[0]    = 1'b0;
      latch_flush[1] = 1'b1;
      state_nxt      = RUN;
      if (FWD_EN != 0) begin
        lu_nxt = LU_INIT;
        if (LU_INIT != '0) state_nxt = LU_STALL;
      end
    end else if (!hz.ihit) begin
      pc_wen         = 1'b0;
      latch_flush[0] = 1'b1;
      state_nxt      = RUN;
    end else begin
      state_nxt = RUN;
    end
    if (hz.exmem_halt) state_nxt = HALTED;
    if (RST) begin
      pc_wen      = 1'b0;
      latch_en    = '0;
      latch_flush = '1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= RUN;
      lu_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_nxt;
      if (!pc_wen && (state != HALTED) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

  hazard_fwd #(.FWD_EN(FWD_EN)) u_fwd_a (
    .src        (hz.rs),
    .exmem_wsel (hz.exmem_wsel),
    .exmem_wen  (hz.exmem_wen),
    .memwb_wsel (hz.memwb_wsel),
    .memwb_wen  (hz.memwb_wen),
    .sel_c      (fwd_a_c)
  );

  hazard_fwd #(.FWD_EN(FWD_EN)) u_fwd_b (
    .src        (hz.rt),
    .exmem_wsel (hz.exmem_wsel),
    .exmem_wen  (hz.exmem_wen),
    .memwb_wsel (hz.memwb_wsel),
    .memwb_wen  (hz.memwb_wen),
    .sel_c      (fwd_b_c)
  );

  assign hz.pcWEN       = pc_wen;
  assign hz.latch_en    = latch_en;
  assign hz.latch_flush = latch_flush;
  assign hz.fwd_a       = RST ? FWD_NONE : fwd_a_c;
  assign hz.fwd_b       = RST ? FWD_NONE : fwd_b_c;
  assign hz.stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one shared stimulus drives a forwarding DUT
// (LOAD_LAT=3), a no-forwarding DUT and a 4-bit-counter DUT.
module tb_hazard_ctrl;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl_if #(.NLATCH(4), .CNTW(32)) bus ();
  hazard_ctrl_if #(.NLATCH(4), .CNTW(32)) bus_nf ();
  hazard_ctrl_if #(.NLATCH(4), .CNTW(4))  bus_sat ();

  // Mirror the stimulus onto the other two DUTs.
  assign bus_nf.ihit = bus.ihit;                  assign bus_sat.ihit = bus.ihit;
  assign bus_nf.dhit = bus.dhit;                  assign bus_sat.dhit = bus.dhit;
  assign bus_nf.rs = bus.rs;                      assign bus_sat.rs = bus.rs;
  assign bus_nf.rt = bus.rt;                      assign bus_sat.rt = bus.rt;
  assign bus_nf.rs_used = bus.rs_used;            assign bus_sat.rs_used = bus.rs_used;
  assign bus_nf.rt_used = bus.rt_used;            assign bus_sat.rt_used = bus.rt_used;
  assign bus_nf.idex_wsel = bus.idex_wsel;        assign bus_sat.idex_wsel = bus.idex_wsel;
  assign bus_nf.exmem_wsel = bus.exmem_wsel;      assign bus_sat.exmem_wsel = bus.exmem_wsel;
  assign bus_nf.memwb_wsel = bus.memwb_wsel;      assign bus_sat.memwb_wsel = bus.memwb_wsel;
  assign bus_nf.idex_wen = bus.idex_wen;          assign bus_sat.idex_wen = bus.idex_wen;
  assign bus_nf.exmem_wen = bus.exmem_wen;        assign bus_sat.exmem_wen = bus.exmem_wen;
  assign bus_nf.memwb_wen = bus.memwb_wen;        assign bus_sat.memwb_wen = bus.memwb_wen;
  assign bus_nf.idex_memrd = bus.idex_memrd;      assign bus_sat.idex_memrd = bus.idex_memrd;
  assign bus_nf.exmem_memop = bus.exmem_memop;    assign bus_sat.exmem_memop = bus.exmem_memop;
  assign bus_nf.branch_taken = bus.branch_taken;  assign bus_sat.branch_taken = bus.branch_taken;
  assign bus_nf.exmem_halt = bus.exmem_halt;      assign bus_sat.exmem_halt = bus.exmem_halt;

  hazard_ctrl #(.NLATCH(4), .FWD_EN(1), .LOAD_LAT(3), .CNTW(32)) u_dut (
    .CLK (CLK), .RST (RST), .hz (bus.slave)
  );
  hazard_ctrl #(.NLATCH(4), .FWD_EN(0), .LOAD_LAT(1), .CNTW(32)) u_nf (
    .CLK (CLK), .RST (RST), .hz (bus_nf.slave)
  );
  hazard_ctrl #(.NLATCH(4), .FWD_EN(1), .LOAD_LAT(1), .CNTW(4)) u_sat (
    .CLK (CLK), .RST (RST), .hz (bus_sat.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.ihit = 1'b1;        bus.dhit = 1'b1;
    bus.rs = '0;            bus.rt = '0;
    bus.rs_used = 1'b0;     bus.rt_used = 1'b0;
    bus.idex_wsel = '0;     bus.exmem_wsel = '0;    bus.memwb_wsel = '0;
    bus.idex_wen = 1'b0;    bus.exmem_wen = 1'b0;   bus.memwb_wen = 1'b0;
    bus.idex_memrd = 1'b0;  bus.exmem_memop = 1'b0;
    bus.branch_taken = 1'b0; bus.exmem_halt = 1'b0;
  endtask

  task automatic load_use_r5();
    bus.idex_memrd = 1'b1; bus.idex_wen = 1'b1; bus.idex_wsel = 5'd5;
    bus.rs = 5'd5;         bus.rs_used = 1'b1;
  endtask

  initial begin
    // Reset: outputs forced even with a forwarding match present
    RST = 1'b1;
    idle();
    bus.exmem_wen = 1'b1; bus.exmem_wsel = 5'd7; bus.rs = 5'd7;
    #1;
    chk("rst_pcwen", 32'(bus.pcWEN), 32'(1'b0));
    chk("rst_en", 32'(bus.latch_en), 32'(4'b0000));
    chk("rst_flush", 32'(bus.latch_flush), 32'(4'b1111));
    chk("rst_fwd_a", 32'(bus.fwd_a), 32'(FWD_NONE));
    tick();
    chk("rst_cnt", bus.stall_cnt, 32'd0);

    // Idle run
    RST = 1'b0;
    idle();
    #1;
    chk("run_pcwen", 32'(bus.pcWEN), 32'(1'b1));
    chk("run_en", 32'(bus.latch_en), 32'(4'b1111));
    chk("run_flush", 32'(bus.latch_flush), 32'(4'b0000));

    // Forwarding tie and register 0
    bus.exmem_wen = 1'b1; bus.exmem_wsel = 5'd7;
    bus.memwb_wen = 1'b1; bus.memwb_wsel = 5'd7;
    bus.rs = 5'd7; bus.rt = 5'd7;
    #1;
    chk("fwd_tie_a", 32'(bus.fwd_a), 32'(FWD_EXMEM));
    chk("fwd_tie_b", 32'(bus.fwd_b), 32'(FWD_EXMEM));
    chk("fwd_nf_b", 32'(bus_nf.fwd_b), 32'(FWD_NONE));
    bus.exmem_wen = 1'b0;
    #1;
    chk("fwd_memwb_a", 32'(bus.fwd_a), 32'(FWD_MEMWB));
    bus.exmem_wen = 1'b1; bus.exmem_wsel = '0; bus.memwb_wsel = '0; bus.rs = '0;
    #1;
    chk("fwd_r0_a", 32'(bus.fwd_a), 32'(FWD_NONE));
    idle();

    // Load-use, LOAD_LAT=3: three stall cycles
    load_use_r5();
    #1;
    chk("lu1_pcwen", 32'(bus.pcWEN), 32'(1'b0));
    chk("lu1_en", 32'(bus.latch_en), 32'(4'b1110));
    chk("lu1_flush", 32'(bus.latch_flush), 32'(4'b0010));
    tick();
    idle();
    #1;
    chk("lu2_pcwen", 32'(bus.pcWEN), 32'(1'b0));
    chk("lu2_flush", 32'(bus.latch_flush), 32'(4'b0010));
    tick();
    chk("lu3_pcwen", 32'(bus.pcWEN), 32'(1'b0));
    chk("lu3_flush", 32'(bus.latch_flush), 32'(4'b0010));
    tick();
    chk("lu_done_pcwen", 32'(bus.pcWEN), 32'(1'b1));
    chk("lu_cnt", bus.stall_cnt, 32'd3);

    // Mem wait with concurrent branch, then branch flush
    bus.exmem_memop = 1'b1; bus.dhit = 1'b0; bus.branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mw_pcwen", 32'(bus.pcWEN), 32'(1'b0));
      chk("mw_en", 32'(bus.latch_en), 32'(4'b0000));
      chk("mw_flush", 32'(bus.latch_flush), 32'(4'b0000));
      tick();
    end
    bus.dhit = 1'b1;
    #1;
    chk("br_pcwen", 32'(bus.pcWEN), 32'(1'b1));
    chk("br_en", 32'(bus.latch_en), 32'(4'b1111));
    chk("br_flush", 32'(bus.latch_flush), 32'(4'b0011));
    tick();
    idle();
    chk("mw_cnt", bus.stall_cnt, 32'd7);

    // Branch cancels a pending load-use stall
    load_use_r5();
    tick();
    idle();
    bus.branch_taken = 1'b1;
    #1;
    chk("brc_flush", 32'(bus.latch_flush), 32'(4'b0011));
    chk("brc_pcwen", 32'(bus.pcWEN), 32'(1'b1));
    tick();
    idle();
    #1;
    chk("brc_run_pcwen", 32'(bus.pcWEN), 32'(1'b1));

    // Instruction cache miss
    bus.ihit = 1'b0;
    #1;
    chk("im_pcwen", 32'(bus.pcWEN), 32'(1'b0));
    chk("im_en", 32'(bus.latch_en), 32'(4'b1111));
    chk("im_flush", 32'(bus.latch_flush), 32'(4'b0001));
    tick();
    idle();
    chk("im_cnt", bus.stall_cnt, 32'd9);

    // Halt, drain for 10 cycles, then reset
    bus.exmem_halt = 1'b1;
    #1;
    chk("halt_req_pcwen", 32'(bus.pcWEN), 32'(1'b1));
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("halt_pcwen", 32'(bus.pcWEN), 32'(1'b0));
      chk("halt_flush", 32'(bus.latch_flush), 32'(4'b0001));
      tick();
    end
    chk("halt_cnt", bus.stall_cnt, 32'd9);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("unhalt_pcwen", 32'(bus.pcWEN), 32'(1'b1));
    chk("unhalt_cnt", bus.stall_cnt, 32'd0);

    // No forwarding: writer of $3 walks IDEX -> EXMEM -> MEMWB
    bus.rt = 5'd3; bus.rt_used = 1'b1;
    bus.idex_wen = 1'b1; bus.idex_wsel = 5'd3;
    #1;
    chk("nf1_pcwen", 32'(bus_nf.pcWEN), 32'(1'b0));
    chk("nf1_flush", 32'(bus_nf.latch_flush), 32'(4'b0010));
    chk("nf1_en", 32'(bus_nf.latch_en), 32'(4'b1110));
    chk("nf1_fwd_b", 32'(bus_nf.fwd_b), 32'(FWD_NONE));
    tick();
    bus.idex_wen = 1'b0; bus.idex_wsel = '0;
    bus.exmem_wen = 1'b1; bus.exmem_wsel = 5'd3;
    #1;
    chk("nf2_pcwen", 32'(bus_nf.pcWEN), 32'(1'b0));
    chk("nf2_fwd_b", 32'(bus_nf.fwd_b), 32'(FWD_NONE));
    chk("fw2_fwd_b", 32'(bus.fwd_b), 32'(FWD_EXMEM));
    tick();
    bus.exmem_wen = 1'b0; bus.exmem_wsel = '0;
    bus.memwb_wen = 1'b1; bus.memwb_wsel = 5'd3;
    #1;
    chk("nf3_pcwen", 32'(bus_nf.pcWEN), 32'(1'b0));
    chk("nf3_fwd_b", 32'(bus_nf.fwd_b), 32'(FWD_NONE));
    chk("fw3_fwd_b", 32'(bus.fwd_b), 32'(FWD_MEMWB));
    tick();
    bus.memwb_wen = 1'b0; bus.memwb_wsel = '0;
    #1;
    chk("nf4_pcwen", 32'(bus_nf.pcWEN), 32'(1'b1));
    chk("nf_cnt", bus_nf.stall_cnt, 32'd3);
    idle();

    // Counter saturation on the 4-bit instance
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.ihit = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    idle();
    chk("sat_cnt", 32'(bus_sat.stall_cnt), 32'd15);
    chk("nosat_cnt", bus.stall_cnt, 32'd20);

    // Reset in the middle of a load-use stall
    load_use_r5();
    tick();
    RST = 1'b1;
    idle();
    tick();
    RST = 1'b0;
    #1;
    chk("rstmid_pcwen", 32'(bus.pcWEN), 32'(1'b1));
    chk("rstmid_cnt", bus.stall_cnt, 32'd0);
    tick();
    chk("rstmid_pcwen2", 32'(bus.pcWEN), 32'(1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
